// File: rtl/inputc_rx_pkg.sv
// Shared constants and flit-type helpers for the inputc_rx receive channel.
package inputc_rx_pkg;

  localparam int DATAW    = 15;
  localparam int VCH      = 1;
  localparam int VCHW     = 0;
  localparam int NVC      = VCH + 1;
  localparam int FIFO_P1  = 4;
  localparam int FIFOD_P1 = 1;
  localparam int PTRW     = FIFOD_P1 + 1;
  localparam int CNTW     = FIFOD_P1 + 2;
  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 14;

  typedef enum logic [1:0] {
    TYPE_DATA     = 2'b00,
    TYPE_HEAD     = 2'b01,
    TYPE_TAIL     = 2'b10,
    TYPE_HEADTAIL = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [DATAW:0] flit);
    return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
  endfunction

  function automatic logic opens_packet(input logic [DATAW:0] flit);
    return (flit_type(flit) == TYPE_HEAD) || (flit_type(flit) == TYPE_HEADTAIL);
  endfunction

  function automatic logic closes_packet(input logic [DATAW:0] flit);
    return (flit_type(flit) == TYPE_TAIL) || (flit_type(flit) == TYPE_HEADTAIL);
  endfunction

endpackage

// File: rtl/inputc_rx_if.sv
// Link-side and switch-side signals of one input channel; the receiver uses the
// slave view, the upstream router / switch allocator side uses the master view.
interface inputc_rx_if;
  import inputc_rx_pkg::*;

  logic [DATAW:0] idata;
  logic           ivalid;
  logic [VCHW:0]  ivch;
  logic [VCH:0]   oack;
  logic [VCH:0]   olck;
  logic [VCH:0]   oreq;
  logic [VCH:0]   igrant;
  logic [DATAW:0] odata;
  logic           ovalid;
  logic [VCHW:0]  ovch;
  logic           oerr;

  modport master (
    output idata, ivalid, ivch, igrant,
    input  oack, olck, oreq, odata, ovalid, ovch, oerr
  );

  modport slave (
    input  idata, ivalid, ivch, igrant,
    output oack, olck, oreq, odata, ovalid, ovch, oerr
  );

endinterface

// File: rtl/inputc_rx_vc_fifo.sv
// Single-VC circular flit buffer. Callers must never write when full or read
// when empty; the parent qualifies wr/rd before they get here.
module vc_fifo
  import inputc_rx_pkg::*;
(
  input  logic            clk,
  input  logic            rst_,
  input  logic            wr,
  input  logic [DATAW:0]  wdata,
  input  logic            rd,
  output logic [DATAW:0]  rdata,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  localparam logic [PTRW-1:0] LAST = PTRW'(FIFO_P1 - 1);

  logic [DATAW:0]  mem [FIFO_P1];
  logic [PTRW-1:0] wptr;
  logic [PTRW-1:0] rptr;

  // Pointers wrap at the configured depth, which need not be a power of two.
  function automatic logic [PTRW-1:0] bump(input logic [PTRW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= bump(wptr);
      if (rd) rptr <= bump(rptr);
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CNTW'(FIFO_P1));
  assign empty = (count == '0);

endmodule

// File: rtl/inputc_rx.sv
// Receive end of one physical channel: per-VC flit buffering, grant decode,
// registered dequeue output, packet lock tracking and sticky error flag.
module inputc_rx
  import inputc_rx_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0
)
(
  input  logic        clk,
  input  logic        rst_,
  inputc_rx_if.slave  rx
);

  localparam int VW = VCHW + 1;

  logic [VCH:0]    fifo_wr;
  logic [VCH:0]    fifo_rd;
  logic [VCH:0]    fifo_full;
  logic [VCH:0]    fifo_empty;
  logic [DATAW:0]  fifo_rdata [NVC];
  logic [CNTW-1:0] fifo_count [NVC];
  logic [CNTW-1:0] pktcnt     [NVC];
  logic [VCH:0]    pkt_inc;
  logic [VCH:0]    pkt_dec;
  logic [VCHW:0]   sel;
  logic            served;
  logic            multihot;
  logic            err_set;

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    // A flit arriving at a full FIFO is dropped rather than overwriting.
    assign fifo_wr[v] = rx.ivalid && (rx.ivch == VW'(v)) && !fifo_full[v];

    vc_fifo u_fifo (
      .clk   (clk),
      .rst_  (rst_),
      .wr    (fifo_wr[v]),
      .wdata (rx.idata),
      .rd    (fifo_rd[v]),
      .rdata (fifo_rdata[v]),
      .full  (fifo_full[v]),
      .empty (fifo_empty[v]),
      .count (fifo_count[v])
    );

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_)
      fifo_count[v] <= CNTW'(FIFO_P1))
      else $error("inputc_rx router %0d pch %0d vc %0d occupancy overflow", ROUTERID, PCHID, v);
  end

  // Lowest-index granted VC wins; anything other than a clean one-hot grant
  // to a non-empty VC is flagged as a protocol error.
  always_comb begin
    sel = '0;
    for (int v = VCH; v >= 0; v--) begin
      if (rx.igrant[v]) sel = VW'(v);
    end
    multihot = (rx.igrant & (rx.igrant - 1'b1)) != '0;
    served   = (rx.igrant != '0) && !fifo_empty[sel];
    fifo_rd  = '0;
    if (served) fifo_rd[sel] = 1'b1;
    err_set  = multihot
            || ((rx.igrant != '0) && fifo_empty[sel])
            || (rx.ivalid && fifo_full[rx.ivch]);
  end

  always_comb begin
    pkt_inc = '0;
    pkt_dec = '0;
    rx.oreq = '0;
    rx.olck = '0;
    for (int v = 0; v < NVC; v++) begin
      pkt_inc[v] = fifo_wr[v] && opens_packet(rx.idata);
      pkt_dec[v] = fifo_rd[v] && closes_packet(fifo_rdata[v]);
      rx.oreq[v] = !fifo_empty[v];
      rx.olck[v] = (pktcnt[v] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) pktcnt[v] <= '0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        case ({pkt_inc[v], pkt_dec[v]})
          2'b10:   pktcnt[v] <= pktcnt[v] + 1'b1;
          2'b01:   pktcnt[v] <= pktcnt[v] - 1'b1;
          default: pktcnt[v] <= pktcnt[v];
        endcase
      end
    end
  end

  // Output register: idle cycles drive zeros so downstream sees clean data.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx.odata  <= '0;
      rx.ovalid <= 1'b0;
      rx.ovch   <= '0;
      rx.oack   <= '0;
      rx.oerr   <= 1'b0;
    end else begin
      rx.ovalid <= served;
      rx.odata  <= served ? fifo_rdata[sel] : '0;
      rx.ovch   <= served ? sel : '0;
      rx.oack   <= fifo_rd;
      if (err_set) rx.oerr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inputc_rx.sv
// Scoreboard bench for inputc_rx: per-VC queue reference model, directed
// scenarios followed by legal-packet random traffic.
module tb_inputc_rx;
  import inputc_rx_pkg::*;

  localparam int VW = VCHW + 1;

  typedef struct {
    logic [DATAW:0] data;
    int             vch;
    int             due;
  } exp_t;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   edges = 0;

  exp_t           exp_q [$];
  exp_t           mon_e;
  logic [DATAW:0] mq [NVC][$];
  int             mpkt [NVC];
  bit             merr;

  inputc_rx_if bus ();

  inputc_rx #(.ROUTERID(0), .PCHID(0)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .rx   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, required finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  function automatic logic [DATAW:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p[TYPE_LSB-1:0]};
  endfunction

  function automatic bit is_tail(input logic [DATAW:0] f);
    return (f[TYPE_MSB:TYPE_LSB] == TYPE_TAIL) || (f[TYPE_MSB:TYPE_LSB] == TYPE_HEADTAIL);
  endfunction

  function automatic bit is_head(input logic [DATAW:0] f);
    return (f[TYPE_MSB:TYPE_LSB] == TYPE_HEAD) || (f[TYPE_MSB:TYPE_LSB] == TYPE_HEADTAIL);
  endfunction

  // Reference model: decisions use the queue contents before the edge.
  function automatic void modelStep(input bit v, input int ch, input logic [DATAW:0] d,
                                    input logic [VCH:0] g);
    int             pick;
    bit             drop;
    logic [DATAW:0] f;
    pick = -1;
    for (int i = 0; i < NVC; i++) begin
      if (g[i] && pick < 0) pick = i;
    end
    drop = v && (mq[ch].size() >= FIFO_P1);
    if (pick >= 0) begin
      if ($countones(g) > 1) merr = 1'b1;
      if (mq[pick].size() == 0) merr = 1'b1;
      else begin
        f = mq[pick].pop_front();
        exp_q.push_back('{data: f, vch: pick, due: edges + 1});
        if (is_tail(f)) mpkt[pick]--;
      end
    end
    if (v) begin
      if (drop) merr = 1'b1;
      else begin
        mq[ch].push_back(d);
        if (is_head(d)) mpkt[ch]++;
      end
    end
  endfunction

  task automatic applyStimulus(input bit v, input int ch, input logic [DATAW:0] d,
                               input logic [VCH:0] g);
    @(posedge clk);
    #3;
    bus.ivalid = v;
    bus.ivch   = VW'(ch);
    bus.idata  = v ? d : '0;
    bus.igrant = g;
    modelStep(v, ch, d, g);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, '0, '0);
  endtask

  task automatic checkResetState();
    checkOutput("rst_odata",  32'(bus.odata),  32'h0);
    checkOutput("rst_ovalid", 32'(bus.ovalid), 32'h0);
    checkOutput("rst_ovch",   32'(bus.ovch),   32'h0);
    checkOutput("rst_oack",   32'(bus.oack),   32'h0);
    checkOutput("rst_olck",   32'(bus.olck),   32'h0);
    checkOutput("rst_oreq",   32'(bus.oreq),   32'h0);
    checkOutput("rst_oerr",   32'(bus.oerr),   32'h0);
  endtask

  // Reset lands mid-cycle, so outputs are checked before the next edge.
  task automatic resetDut();
    @(posedge clk);
    #3;
    bus.ivalid = 1'b0;
    bus.ivch   = '0;
    bus.idata  = '0;
    bus.igrant = '0;
    #2;
    rst_ = 1'b0;
    #1;
    checkResetState();
    for (int i = 0; i < NVC; i++) begin
      mq[i].delete();
      mpkt[i] = 0;
    end
    exp_q.delete();
    merr = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_ = 1'b1;
  endtask

  always @(posedge clk) begin
    logic [VCH:0] expreq;
    logic [VCH:0] explck;
    edges = edges + 1;
    #1;
    if (rst_) begin
      if (bus.ovalid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spurious_ovalid: got ovch=%0d odata=%0h, required no output",
                   bus.ovch, bus.odata);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("odata",   32'(bus.odata), 32'(mon_e.data));
          checkOutput("ovch",    32'(bus.ovch),  32'(mon_e.vch));
          checkOutput("oack",    32'(bus.oack),  32'(1 << mon_e.vch));
          checkOutput("latency", 32'(edges),     32'(mon_e.due));
        end
      end else begin
        while (exp_q.size() != 0 && exp_q[0].due <= edges) begin
          mon_e = exp_q.pop_front();
          total++;
          bad++;
          $display("[TB] FAIL missing_ovalid: got ovalid=0, required flit %0h on vc %0d",
                   mon_e.data, mon_e.vch);
        end
        checkOutput("idle_outputs", 32'({bus.odata, bus.ovch, bus.oack}), 32'h0);
      end
      for (int i = 0; i < NVC; i++) begin
        expreq[i] = (mq[i].size() != 0);
        explck[i] = (mpkt[i] != 0);
      end
      checkOutput("oreq", 32'(bus.oreq), 32'(expreq));
      checkOutput("olck", 32'(bus.olck), 32'(explck));
      checkOutput("oerr", 32'(bus.oerr), 32'(merr));
    end
  end

  initial begin
    bit             inpkt [NVC];
    int             ch;
    bit             v;
    logic [1:0]     t;
    logic [VCH:0]   g;
    int             r;

    bus.ivalid = 1'b0;
    bus.ivch   = '0;
    bus.idata  = '0;
    bus.igrant = '0;
    merr       = 1'b0;
    for (int i = 0; i < NVC; i++) mpkt[i] = 0;

    repeat (2) @(posedge clk);
    #3;
    checkResetState();
    rst_ = 1'b1;

    $display("[TB] single HEADTAIL on vc0, grant two cycles later");
    applyStimulus(1'b1, 0, mk(TYPE_HEADTAIL, 32'h123), 2'b00);
    applyStimulus(1'b0, 0, '0, 2'b00);
    applyStimulus(1'b0, 0, '0, 2'b01);
    idleCycles(2);

    $display("[TB] four-flit packet on vc1 at full rate");
    applyStimulus(1'b1, 1, mk(TYPE_HEAD, 32'h0a1), 2'b00);
    applyStimulus(1'b1, 1, mk(TYPE_DATA, 32'h0a2), 2'b10);
    applyStimulus(1'b1, 1, mk(TYPE_DATA, 32'h0a3), 2'b10);
    applyStimulus(1'b1, 1, mk(TYPE_TAIL, 32'h0a4), 2'b10);
    applyStimulus(1'b0, 0, '0, 2'b10);
    idleCycles(2);

    $display("[TB] fill vc0 then overflow by one");
    for (int i = 0; i < FIFO_P1; i++)
      applyStimulus(1'b1, 0, mk((i == 0) ? TYPE_HEAD : TYPE_DATA, 32'h100 + i), 2'b00);
    applyStimulus(1'b1, 0, mk(TYPE_DATA, 32'h1ff), 2'b00);
    idleCycles(1);
    for (int i = 0; i < FIFO_P1; i++) applyStimulus(1'b0, 0, '0, 2'b01);
    idleCycles(2);
    resetDut();

    $display("[TB] simultaneous enqueue and dequeue on vc0");
    applyStimulus(1'b1, 0, mk(TYPE_HEAD, 32'h200), 2'b00);
    applyStimulus(1'b1, 0, mk(TYPE_DATA, 32'h201), 2'b00);
    for (int i = 0; i < 2 * FIFO_P1; i++)
      applyStimulus(1'b1, 0, mk(TYPE_DATA, 32'h210 + i), 2'b01);
    applyStimulus(1'b1, 0, mk(TYPE_TAIL, 32'h2ff), 2'b01);
    applyStimulus(1'b0, 0, '0, 2'b01);
    applyStimulus(1'b0, 0, '0, 2'b01);
    idleCycles(2);
    resetDut();

    $display("[TB] multi-hot grant with interleaved vc0/vc1 traffic");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, i % 2, mk(TYPE_HEADTAIL, 32'h300 + i), 2'b11);
    idleCycles(2);
    resetDut();

    $display("[TB] grant to an empty vc");
    applyStimulus(1'b0, 0, '0, 2'b01);
    idleCycles(2);
    resetDut();

    $display("[TB] asynchronous reset mid-packet, then a fresh packet");
    applyStimulus(1'b1, 1, mk(TYPE_HEAD, 32'h400), 2'b00);
    applyStimulus(1'b1, 1, mk(TYPE_DATA, 32'h401), 2'b10);
    resetDut();
    applyStimulus(1'b1, 1, mk(TYPE_HEADTAIL, 32'h410), 2'b00);
    applyStimulus(1'b0, 0, '0, 2'b10);
    idleCycles(2);

    $display("[TB] random legal traffic");
    for (int i = 0; i < NVC; i++) inpkt[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      ch = $urandom_range(0, VCH);
      v  = ($urandom_range(0, 3) != 0) && (mq[ch].size() < FIFO_P1);
      if (!inpkt[ch]) t = ($urandom_range(0, 1) != 0) ? TYPE_HEAD : TYPE_HEADTAIL;
      else            t = ($urandom_range(0, 2) == 0) ? TYPE_TAIL : TYPE_DATA;
      if (v) inpkt[ch] = (t == TYPE_HEAD) || (t == TYPE_DATA);
      r = $urandom_range(0, 9);
      if (r < 6)      g = VCH'(1) << $urandom_range(0, VCH);
      else if (r < 7) g = '1;
      else            g = '0;
      applyStimulus(v, ch, mk(t, $urandom), g);
    end
    for (int n = 0; n < 2 * FIFO_P1 * NVC; n++)
      applyStimulus(1'b0, 0, '0, VCH'(1) << (n % NVC));
    idleCycles(3);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
